prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter OUT_BITS, default 4: bits received per enabled cycle.
REQ-002 SHALL have parameter N_BITS_REGS, default 31: LFSR length.
REQ-003 SHALL have parameter POLY[30:0], default 31'b1001000000000000000000000000000: feedback taps, same encoding as the team's PRNG generator.
REQ-004 SHALL have parameter LOCK_CNT, default 16: consecutive good words required to lock.
REQ-005 SHALL have parameter LOSS_CNT, default 4: consecutive bad words that drop lock.
REQ-006 SHALL have parameter ERR_W, default 16: error counter width.
REQ-007 SHALL have port clk_in  input  1  clock, rising edge.
REQ-008 SHALL have port rst_in_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port ena_in  input  1  data_in valid for this cycle.
REQ-010 SHALL have port data_in  input  OUT_BITS  received PRBS word, generator bit order.
REQ-011 SHALL have port clear_in  input  1  synchronous clear of err_cnt_out.
REQ-012 SHALL have port locked_out  output  1  high while in LOCKED.
REQ-013 SHALL have port err_out  output  1  one-cycle pulse per mismatching word while LOCKED.
REQ-014 SHALL have port err_cnt_out  output  ERR_W  saturating count of bit errors.

Function
REQ-015 SHALL hold a shadow register of N_BITS_REGS bits; next(s) SHALL equal the generator recurrence: bits [OUT_BITS-1:0] = XOR-reductions of s with POLY shifted right by (OUT_BITS-1-i), upper bits = s shifted up by OUT_BITS.
REQ-016 SHALL define pred = next(shadow)[OUT_BITS-1:0] and mism = pred XOR data_in.
REQ-017 SHALL implement states HUNT, VERIFY and LOCKED; nothing changes in a cycle with ena_in=0, except clear_in.
REQ-018 HUNT: each enabled word SHALL set shadow <= {shadow[N-OUT-1:0], data_in} and increment fill count; after FILL = ceil(N_BITS_REGS/OUT_BITS) words (8 at defaults), go to VERIFY.
REQ-019 HUNT boundary: if shadow is all-zero once fill completes, SHALL restart the fill in HUNT and SHALL NOT enter VERIFY.
REQ-020 VERIFY: each enabled word SHALL be compared against pred; shadow SHALL reload by shifting in data_in (self-synchronising).
REQ-021 VERIFY: mism != 0 SHALL return the FSM to HUNT with fill and good counts cleared; the LOCK_CNT-th consecutive good word SHALL enter LOCKED.
REQ-022 LOCKED: shadow SHALL free-run as shadow <= next(shadow), independent of data_in.
REQ-023 LOCKED: a word with mism != 0 SHALL pulse err_out the following cycle and add popcount(mism) to err_cnt_out.
REQ-024 LOCKED: LOSS_CNT consecutive bad words SHALL return the FSM to HUNT; any good word SHALL reset the bad-word count.
REQ-025 err_cnt_out SHALL saturate at 2^ERR_W-1, never wrap, and count only in LOCKED.
REQ-026 clear_in SHALL zero err_cnt_out next cycle; clear_in and an error in the same cycle SHALL give 0.
REQ-027 All outputs SHALL be registered; locked_out SHALL rise on the clock edge that enters LOCKED.

Reset
REQ-028 Asserting rst_in_n low SHALL asynchronously set state=HUNT, shadow=0, all counts=0, locked_out=0, err_out=0 and err_cnt_out=0, including mid-lock.
REQ-029 Reset release SHALL start a fresh HUNT fill on the first enabled word.

Structure
REQ-030 A shared package SHALL hold the default POLY, the FSM state encoding, and the default OUT_BITS/N_BITS_REGS.
REQ-031 A combinational sub-module prbs_step SHALL compute next(s) and SHALL be reusable by the generator.
REQ-032 The popcount SHALL be a local function; the target is 120-400 lines of RTL.

Verification
REQ-033 Reset with ena_in=1 and random data_in -> locked_out=0, err_out=0, err_cnt_out=0 throughout reset.
REQ-034 Default generator stream (initial state 1<<30) fed continuously -> locked_out rises after 24 enabled words (8 fill + 16 verify); err_cnt_out stays 0.
REQ-035 Locked, flip bit 0 of one word -> one err_out pulse, err_cnt_out=1; flip all 4 bits of a later word -> err_cnt_out=5, locked_out stays 1.
REQ-036 Locked, replace stream with inverted data for 4 words -> locked_out falls after the 4th; a clean stream then relocks after 24 words.
REQ-037 data_in=0 for 200 enabled words -> locked_out never rises (all-zero trap).
REQ-038 With ERR_W=4 forced, inject 20 bit errors -> err_cnt_out holds at 15; clear_in together with an error -> 0; ena_in=0 gaps inserted -> lock and counts unchanged.

Source files
------------

// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS checker and the companion PRNG generator:
// default word width, register length, feedback taps and checker FSM encoding.
package prbs_checker_pkg;

    localparam int          DEF_OUT_BITS    = 4;
    localparam int          DEF_N_BITS_REGS = 31;
    localparam logic [30:0] DEF_POLY        = 31'b1001000000000000000000000000000;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

endpackage

// File: rtl/prbs_step.sv
// One word-step of the PRBS recurrence; shared by the generator and the checker
// so both sides advance the register identically.
module prbs_step
    import prbs_checker_pkg::*;
#(
    parameter int                     OUT_BITS    = DEF_OUT_BITS,
    parameter int                     N_BITS_REGS = DEF_N_BITS_REGS,
    parameter logic [N_BITS_REGS-1:0] POLY        = DEF_POLY
) (
    input  logic [N_BITS_REGS-1:0] state_i,
    output logic [N_BITS_REGS-1:0] next_o
);

    logic [OUT_BITS-1:0] fb_s;

    // Feedback bit i uses the taps advanced by (OUT_BITS-1-i) serial shifts.
    always_comb begin
        fb_s = {OUT_BITS{1'b0}};
        for (int i = 0; i < OUT_BITS; i++) begin
            fb_s[i] = ^(state_i & (POLY >> (OUT_BITS - 1 - i)));
        end
    end

    assign next_o = {state_i[N_BITS_REGS-OUT_BITS-1:0], fb_s};

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunts for a non-zero seed in the received
// stream, verifies it, then free-runs and counts bit errors while locked.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int                     OUT_BITS    = DEF_OUT_BITS,
    parameter int                     N_BITS_REGS = DEF_N_BITS_REGS,
    parameter logic [N_BITS_REGS-1:0] POLY        = DEF_POLY,
    parameter int                     LOCK_CNT    = 16,
    parameter int                     LOSS_CNT    = 4,
    parameter int                     ERR_W       = 16
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic                ena_in,
    input  logic [OUT_BITS-1:0] data_in,
    input  logic                clear_in,
    output logic                locked_out,
    output logic                err_out,
    output logic [ERR_W-1:0]    err_cnt_out
);

    localparam int FILL   = (N_BITS_REGS + OUT_BITS - 1) / OUT_BITS;
    localparam int FILL_W = $clog2(FILL + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(LOSS_CNT + 1);
    localparam int PC_W   = $clog2(OUT_BITS + 1);
    localparam int SUM_W  = ERR_W + 1;

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_CNT - 1);

    function automatic logic [PC_W-1:0] popcount(input logic [OUT_BITS-1:0] v);
        logic [PC_W-1:0] c;
        c = {PC_W{1'b0}};
        for (int i = 0; i < OUT_BITS; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    state_e                 state_q, state_d;
    logic [N_BITS_REGS-1:0] shadow_q, shadow_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [GOOD_W-1:0]      good_q, good_d;
    logic [BAD_W-1:0]       bad_q, bad_d;
    logic                   locked_q, locked_d;
    logic                   err_q, err_d;
    logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;

    logic [N_BITS_REGS-1:0] next_s;
    logic [N_BITS_REGS-1:0] shift_in_s;
    logic [OUT_BITS-1:0]    mism_s;
    logic                   mism_nz_s;
    logic [SUM_W-1:0]       err_sum_s;
    logic [ERR_W-1:0]       err_cnt_sat_s;

    prbs_step #(
        .OUT_BITS    (OUT_BITS),
        .N_BITS_REGS (N_BITS_REGS),
        .POLY        (POLY)
    ) u_step (
        .state_i (shadow_q),
        .next_o  (next_s)
    );

    assign shift_in_s    = {shadow_q[N_BITS_REGS-OUT_BITS-1:0], data_in};
    assign mism_s        = next_s[OUT_BITS-1:0] ^ data_in;
    assign mism_nz_s     = |mism_s;
    assign err_sum_s     = {1'b0, err_cnt_q} + SUM_W'(popcount(mism_s));
    assign err_cnt_sat_s = err_sum_s[ERR_W] ? {ERR_W{1'b1}} : err_sum_s[ERR_W-1:0];

    // Next-state logic for the hunt/verify/locked sequence and its counters.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        fill_d   = fill_q;
        good_d   = good_q;
        bad_d    = bad_q;
        err_d    = 1'b0;
        if (ena_in) begin
            case (state_q)
                ST_HUNT: begin
                    shadow_d = shift_in_s;
                    if (fill_q == FILL_LAST) begin
                        // An all-zero seed would lock onto a dead stream; refill instead.
                        fill_d = {FILL_W{1'b0}};
                        good_d = {GOOD_W{1'b0}};
                        if (shift_in_s == {N_BITS_REGS{1'b0}}) begin
                            state_d = ST_HUNT;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                ST_VERIFY: begin
                    shadow_d = shift_in_s;
                    if (mism_nz_s) begin
                        state_d = ST_HUNT;
                        fill_d  = {FILL_W{1'b0}};
                        good_d  = {GOOD_W{1'b0}};
                    end else if (good_q == GOOD_LAST) begin
                        state_d = ST_LOCKED;
                        good_d  = {GOOD_W{1'b0}};
                        bad_d   = {BAD_W{1'b0}};
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    shadow_d = next_s;
                    if (mism_nz_s) begin
                        err_d = 1'b1;
                        if (bad_q == BAD_LAST) begin
                            state_d = ST_HUNT;
                            fill_d  = {FILL_W{1'b0}};
                            good_d  = {GOOD_W{1'b0}};
                            bad_d   = {BAD_W{1'b0}};
                        end else begin
                            bad_d = bad_q + BAD_W'(1);
                        end
                    end else begin
                        bad_d = {BAD_W{1'b0}};
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    fill_d  = {FILL_W{1'b0}};
                    good_d  = {GOOD_W{1'b0}};
                    bad_d   = {BAD_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // Error counter: clear wins over a simultaneous error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_in) begin
            err_cnt_d = {ERR_W{1'b0}};
        end else if (err_d) begin
            err_cnt_d = err_cnt_sat_s;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, shadow, counters and registered outputs.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q   <= ST_HUNT;
            shadow_q  <= {N_BITS_REGS{1'b0}};
            fill_q    <= {FILL_W{1'b0}};
            good_q    <= {GOOD_W{1'b0}};
            bad_q     <= {BAD_W{1'b0}};
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= {ERR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            fill_q    <= fill_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked_out  = locked_q;
    assign err_out     = err_q;
    assign err_cnt_out = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a default instance and an ERR_W=4 instance share one
// stimulus stream; expectations are queued per driven word and checked after its edge.
module tb_prbs_checker;

    logic        clk_in = 1'b0;
    logic        rst_in_n;
    logic        ena_in;
    logic        clear_in;
    logic [3:0]  data_in;
    logic        locked_out, err_out;
    logic [15:0] err_cnt_out;
    logic        locked4, err4;
    logic [3:0]  err_cnt4;

    always #5 clk_in = ~clk_in;

    prbs_checker dut (
        .clk_in      (clk_in),
        .rst_in_n    (rst_in_n),
        .ena_in      (ena_in),
        .data_in     (data_in),
        .clear_in    (clear_in),
        .locked_out  (locked_out),
        .err_out     (err_out),
        .err_cnt_out (err_cnt_out)
    );

    prbs_checker #(.ERR_W(4)) dut4 (
        .clk_in      (clk_in),
        .rst_in_n    (rst_in_n),
        .ena_in      (ena_in),
        .data_in     (data_in),
        .clear_in    (clear_in),
        .locked_out  (locked4),
        .err_out     (err4),
        .err_cnt_out (err_cnt4)
    );

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    int          exp_cnt4 = 0;
    logic [30:0] gen = 31'h4000_0000;

    // Serial reference LFSR x^31 + x^28 + 1, four shifts per word.
    function automatic logic [30:0] lfsr4(input logic [30:0] s);
        logic [30:0] t;
        t = s;
        for (int i = 0; i < 4; i++) t = {t[29:0], t[30] ^ t[27]};
        return t;
    endfunction

    task automatic next_word(output logic [3:0] w);
        gen = lfsr4(gen);
        w = gen[3:0];
    endtask

    task automatic add_err(input int n);
        exp_cnt  = (exp_cnt + n > 65535) ? 65535 : exp_cnt + n;
        exp_cnt4 = (exp_cnt4 + n > 15) ? 15 : exp_cnt4 + n;
    endtask

    task automatic push_exp(input logic lk, input logic er);
        exp_t x;
        x.locked = lk;
        x.err    = er;
        x.cnt    = 16'(exp_cnt);
        x.cnt4   = 4'(exp_cnt4);
        sb.push_back(x);
    endtask

    task automatic drive(input logic [3:0] d, input logic en, input logic clr);
        data_in  = d;
        ena_in   = en;
        clear_in = clr;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in_n = 1'b0;
        exp_cnt = 0;
        exp_cnt4 = 0;
        for (int k = 0; k < 6; k++) begin
            push_exp(1'b0, 1'b0);
            drive(4'($urandom_range(0, 15)), 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({locked_out, err_out, err_cnt_out, locked4, err4, err_cnt4} !== {e.locked, e.err, e.cnt, e.locked, e.err, e.cnt4}) begin
                errors++;
                $display("FAIL reset[%0d]: got locked=%0b/%0b err=%0b/%0b cnt=%0d/%0d, want locked=%0b err=%0b cnt=%0d/%0d",
                         k, locked_out, locked4, err_out, err4, err_cnt_out, err_cnt4, e.locked, e.err, e.cnt, e.cnt4);
            end
        end
        rst_in_n = 1'b1;
    endtask

    task automatic test_lock();
        logic [3:0] w;
        for (int k = 0; k < 28; k++) begin
            next_word(w);
            push_exp(k >= 23, 1'b0);
            drive(w, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({locked_out, err_out, err_cnt_out, locked4, err4, err_cnt4} !== {e.locked, e.err, e.cnt, e.locked, e.err, e.cnt4}) begin
                errors++;
                $display("FAIL lock[%0d]: got locked=%0b/%0b err=%0b/%0b cnt=%0d/%0d, want locked=%0b err=%0b cnt=%0d/%0d",
                         k, locked_out, locked4, err_out, err4, err_cnt_out, err_cnt4, e.locked, e.err, e.cnt, e.cnt4);
            end
        end
    endtask

    task automatic test_bit_errors();
        logic [3:0] w;
        logic [3:0] flips [10];
        flips = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
        for (int k = 0; k < 10; k++) begin
            next_word(w);
            if (flips[k] != 4'h0) add_err($countones(flips[k]));
            push_exp(1'b1, flips[k] != 4'h0);
            drive(w ^ flips[k], 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({locked_out, err_out, err_cnt_out, locked4, err4, err_cnt4} !== {e.locked, e.err, e.cnt, e.locked, e.err, e.cnt4}) begin
                errors++;
                $display("FAIL biterr[%0d]: got locked=%0b/%0b err=%0b/%0b cnt=%0d/%0d, want locked=%0b err=%0b cnt=%0d/%0d",
                         k, locked_out, locked4, err_out, err4, err_cnt_out, err_cnt4, e.locked, e.err, e.cnt, e.cnt4);
            end
        end
    endtask

    task automatic test_loss_relock();
        logic [3:0] w;
        int         n;
        for (int k = 0; k < 4; k++) begin
            next_word(w);
            add_err(4);
            push_exp(k < 3, 1'b1);
            drive(~w, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({locked_out, err_out, err_cnt_out, locked4, err4, err_cnt4} !== {e.locked, e.err, e.cnt, e.locked, e.err, e.cnt4}) begin
                errors++;
                $display("FAIL loss[%0d]: got locked=%0b/%0b err=%0b/%0b cnt=%0d/%0d, want locked=%0b err=%0b cnt=%0d/%0d",
                         k, locked_out, locked4, err_out, err4, err_cnt_out, err_cnt4, e.locked, e.err, e.cnt, e.cnt4);
            end
        end
        n = 0;
        for (int i = 0; i < 40 && n < 27; i++) begin
            if (i % 5 == 4) begin
                push_exp(n >= 24, 1'b0);
                drive(4'($urandom_range(0, 15)), 1'b0, 1'b0);
            end else begin
                next_word(w);
                n++;
                push_exp(n >= 24, 1'b0);
                drive(w, 1'b1, 1'b0);
            end
            e = sb.pop_front();
            checks++;
            if ({locked_out, err_out, err_cnt_out, locked4, err4, err_cnt4} !== {e.locked, e.err, e.cnt, e.locked, e.err, e.cnt4}) begin
                errors++;
                $display("FAIL relock[%0d]: got locked=%0b/%0b err=%0b/%0b cnt=%0d/%0d, want locked=%0b err=%0b cnt=%0d/%0d",
                         i, locked_out, locked4, err_out, err4, err_cnt_out, err_cnt4, e.locked, e.err, e.cnt, e.cnt4);
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] w;
        logic       bad;
        logic       clr;
        logic       en;
        // step 0 clears, 1..40 alternate single-bit errors, 41..45 are gaps, 46 clears with an error, 47 clean
        for (int k = 0; k < 48; k++) begin
            bad = 1'b0;
            clr = 1'b0;
            en  = 1'b1;
            if (k >= 41 && k <= 45) begin
                en = 1'b0;
                w  = 4'($urandom_range(0, 15));
            end else begin
                next_word(w);
                if (k >= 1 && k <= 40 && (k % 2 == 1)) begin
                    w   = w ^ (4'b0001 << ((k / 2) % 4));
                    bad = 1'b1;
                    add_err(1);
                end else if (k == 46) begin
                    w   = w ^ 4'h2;
                    bad = 1'b1;
                end
            end
            if (k == 0 || k == 46) begin
                clr      = 1'b1;
                exp_cnt  = 0;
                exp_cnt4 = 0;
            end
            push_exp(1'b1, bad);
            drive(w, en, clr);
            e = sb.pop_front();
            checks++;
            if ({locked_out, err_out, err_cnt_out, locked4, err4, err_cnt4} !== {e.locked, e.err, e.cnt, e.locked, e.err, e.cnt4}) begin
                errors++;
                $display("FAIL sat[%0d]: got locked=%0b/%0b err=%0b/%0b cnt=%0d/%0d, want locked=%0b err=%0b cnt=%0d/%0d",
                         k, locked_out, locked4, err_out, err4, err_cnt_out, err_cnt4, e.locked, e.err, e.cnt, e.cnt4);
            end
        end
    endtask

    task automatic test_all_zero();
        logic [3:0] w;
        // Asynchronous reset while locked, observed before the next clock edge.
        #3 rst_in_n = 1'b0;
        exp_cnt  = 0;
        exp_cnt4 = 0;
        #1;
        push_exp(1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({locked_out, err_out, err_cnt_out, locked4, err4, err_cnt4} !== {e.locked, e.err, e.cnt, e.locked, e.err, e.cnt4}) begin
            errors++;
            $display("FAIL async_reset: got locked=%0b/%0b err=%0b/%0b cnt=%0d/%0d, want all zero",
                     locked_out, locked4, err_out, err4, err_cnt_out, err_cnt4);
        end
        drive(4'h0, 1'b1, 1'b0);
        rst_in_n = 1'b1;
        for (int k = 0; k < 224; k++) begin
            if (k < 200) begin
                w = 4'h0;
            end else begin
                next_word(w);
            end
            push_exp(k >= 223, 1'b0);
            drive(w, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({locked_out, err_out, err_cnt_out, locked4, err4, err_cnt4} !== {e.locked, e.err, e.cnt, e.locked, e.err, e.cnt4}) begin
                errors++;
                $display("FAIL zero[%0d]: got locked=%0b/%0b err=%0b/%0b cnt=%0d/%0d, want locked=%0b err=%0b cnt=%0d/%0d",
                         k, locked_out, locked4, err_out, err4, err_cnt_out, err_cnt4, e.locked, e.err, e.cnt, e.cnt4);
            end
        end
    endtask

    initial begin
        rst_in_n = 1'b0;
        ena_in   = 1'b1;
        clear_in = 1'b0;
        data_in  = 4'h0;
        test_reset();
        test_lock();
        test_bit_errors();
        test_loss_relock();
        test_saturation();
        test_all_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
